// File: rtl/cordic_request_scheduler.sv
// Round-robin front end for one shared iterative sin/cos CORDIC core: folds full-circle
// angles into the core's +/-90 degree range, guards each run with a watchdog, and returns tagged results.
module cordic_request_scheduler #(
    parameter  int NUM_REQ = 4,
    parameter  int ID_W    = 2,
    parameter  int TIMEOUT = 40,
    localparam int DATA_W  = 16
) (
    input  logic                        clock_i,
    input  logic                        reset_ni,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [DATA_W*NUM_REQ-1:0]   req_angle_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic                        core_start_o,
    output logic [DATA_W-1:0]           core_angle_o,
    input  logic                        core_done_i,
    input  logic signed [DATA_W-1:0]    core_sine_i,
    input  logic signed [DATA_W-1:0]    core_cosine_i,
    output logic                        res_valid_o,
    output logic [ID_W-1:0]             res_id_o,
    output logic signed [DATA_W-1:0]    res_sine_o,
    output logic signed [DATA_W-1:0]    res_cosine_o,
    output logic                        res_err_o,
    input  logic                        res_ready_i,
    output logic                        busy_o
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [ID_W-1:0]           last_grant_q, last_grant_d;
    logic [ID_W-1:0]           id_q, id_d;
    logic [DATA_W-1:0]         angle_q, angle_d;
    logic                      flip_q, flip_d;
    logic [TMR_W-1:0]          timer_q, timer_d;
    logic signed [DATA_W-1:0]  sine_q, sine_d;
    logic signed [DATA_W-1:0]  cosine_q, cosine_d;
    logic                      err_q, err_d;

    logic [NUM_REQ-1:0]        grant_oh;
    logic [ID_W-1:0]           grant_id;
    logic [DATA_W-1:0]         grant_angle;
    logic [DATA_W:0]           folded;

    // Angles beyond +/-90 degrees are reflected through +/-180; cosine changes sign, sine does not.
    function automatic logic [DATA_W:0] fold_angle(input logic signed [DATA_W-1:0] a);
        logic signed [DATA_W-1:0] qtr_pos;
        logic signed [DATA_W-1:0] qtr_neg;
        qtr_pos = 16'sh4000;
        qtr_neg = -16'sh4000;
        if (a > qtr_pos || a < qtr_neg) begin
            return {1'b1, 16'h8000 - a};
        end
        return {1'b0, a};
    endfunction

    function automatic logic signed [DATA_W-1:0] neg_sat(input logic signed [DATA_W-1:0] v);
        if (v == {1'b1, {(DATA_W-1){1'b0}}}) begin
            return {1'b0, {(DATA_W-1){1'b1}}};
        end
        return -v;
    endfunction

    always_comb begin
        int  idx;
        logic found;
        idx         = 0;
        found       = 1'b0;
        grant_oh    = '0;
        grant_id    = '0;
        grant_angle = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid_i[idx]) begin
                found         = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_id      = ID_W'(idx);
                grant_angle   = req_angle_i[DATA_W*idx +: DATA_W];
            end
        end
    end

    assign folded = fold_angle(grant_angle);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        angle_d      = angle_q;
        flip_d       = flip_q;
        timer_d      = timer_q;
        sine_d       = sine_q;
        cosine_d     = cosine_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (|grant_oh) begin
                    last_grant_d = grant_id;
                    id_d         = grant_id;
                    angle_d      = folded[DATA_W-1:0];
                    flip_d       = folded[DATA_W];
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + TMR_W'(1);
                // A completion in the final watchdog cycle still counts as success.
                if (core_done_i) begin
                    sine_d   = core_sine_i;
                    cosine_d = flip_q ? neg_sat(core_cosine_i) : core_cosine_i;
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    sine_d   = '0;
                    cosine_d = '0;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            angle_q      <= '0;
            flip_q       <= 1'b0;
            timer_q      <= '0;
            sine_q       <= '0;
            cosine_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            angle_q      <= angle_d;
            flip_q       <= flip_d;
            timer_q      <= timer_d;
            sine_q       <= sine_d;
            cosine_q     <= cosine_d;
            err_q        <= err_d;
        end
    end

    // Grant is combinational in IDLE but suppressed while reset is held.
    assign req_ready_o  = (state_q == IDLE && reset_ni) ? grant_oh : '0;
    assign core_start_o = (state_q == LAUNCH);
    assign core_angle_o = angle_q;
    assign res_valid_o  = (state_q == RESP);
    assign res_id_o     = id_q;
    assign res_sine_o   = sine_q;
    assign res_cosine_o = cosine_q;
    assign res_err_o    = err_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: doc/cordic_request_scheduler.md
Name: cordic_request_scheduler

Overview:
- Shares one iterative sine/cosine CORDIC core among NUM_REQ requesters using round-robin arbitration.
- Takes a full-circle angle, folds it into the core's convergence range (±90°), and launches the core with a one-cycle start pulse.
- Waits for core completion, bounded by a watchdog, then corrects quadrant signs and returns a tagged result over a valid/ready handshake.
- Sits between the requesting blocks and the CORDIC core; it is the only driver of the core's start and angle inputs.

Parameters:
- NUM_REQ, 4, number of requesters; must satisfy 2 ≤ NUM_REQ ≤ 2^ID_W.
- ID_W, 2, width of the requester tag returned with each result.
- TIMEOUT, 40, maximum WAIT cycles before the request is aborted with an error.

Ports:
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- req_valid  in  NUM_REQ  per-requester request strobe.
- req_angle  in  16*NUM_REQ  packed signed angles; requester i occupies bits [16i+15:16i]. Scale: 0x2000 = π/4, 0x4000 = π/2, −0x8000 = −π.
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- core_start  out  1  one-cycle launch pulse to the core.
- core_angle  out  16  folded angle to the core; held stable from LAUNCH through WAIT.
- core_done  in  1  core completion strobe; sampled in WAIT only.
- core_sine  in  16  signed core sine result, Q1.14.
- core_cosine  in  16  signed core cosine result, Q1.14.
- res_valid  out  1  result available.
- res_id  out  ID_W  index of the requester that owns the result.
- res_sine  out  16  signed corrected sine.
- res_cosine  out  16  signed corrected cosine.
- res_err  out  1  1 = watchdog abort; sine and cosine are then 0.
- res_ready  in  1  downstream accepts the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset==0 at a clock edge), from any state including mid-WAIT:
  - state → IDLE.
  - req_ready, core_start, res_valid, res_err, busy all 0.
  - core_angle, res_sine, res_cosine, res_id all 0.
  - Watchdog timer cleared.
  - last_grant = NUM_REQ−1, so requester 0 has top priority first.
  - A core_done arriving during reset is ignored.
- State machine: IDLE → LAUNCH → WAIT → RESP → IDLE.
- IDLE:
  - req_ready is combinational: a one-hot bit for the first requester with req_valid set, searching from last_grant+1 upward and wrapping modulo NUM_REQ.
  - All zeros when no request is pending.
  - On the grant edge, register the id and the folded angle, set last_grant = id, and go to LAUNCH.
  - A requester that drops req_valid before being granted is not served. No request is ever lost once granted.
- Folding, computed from the granted angle a:
  - If a > 0x4000 or a < −0x4000 (signed): core_angle = 0x8000 − a (16-bit wrap) and set flip = 1.
  - Otherwise: core_angle = a and flip = 0.
  - Boundaries: ±0x4000 do not fold. a = −0x8000 folds to 0x0000 with flip = 1.
- LAUNCH: core_start = 1 for exactly this cycle; clear the timer; go to WAIT. Latency from grant edge to core_start high is 1 cycle.
- WAIT: the timer increments each cycle.
  - If core_done = 1: register res_sine = core_sine; res_cosine = flip ? −core_cosine : core_cosine, saturating −(−32768) to 32767; res_err = 0; go to RESP.
  - Else if timer == TIMEOUT−1: res_sine = 0, res_cosine = 0, res_err = 1; go to RESP.
  - core_done and timeout in the same cycle: done wins.
- RESP: res_valid = 1; outputs held stable until res_valid & res_ready, then go to IDLE.
  - The next grant can occur on the cycle after the handshake.
  - Stalling res_ready indefinitely is legal; no new grant is issued meanwhile.
- Throughput: one request in flight at a time. Minimum per-request latency, grant to res_valid, is 3 cycles plus core latency.

Test Plan:
- Single request: req_valid[0] = 1, angle 0x2000 (45°); core model returns sine = cosine = 0x2D41 after 32 cycles → core_start 1 cycle after grant, core_angle = 0x2000, res_id = 0, res_sine = 0x2D41, res_cosine = 0x2D41, res_err = 0.
- Folding: angle 0x6000 (135°) → core_angle = 0x2000; core returns 0x2D41/0x2D41 → res_sine = 0x2D41, res_cosine = 0xD2BF. Angle −0x8000 → core_angle = 0x0000; core returns 0/0x4000 → res_cosine = 0xC000.
- Round-robin: all four req_valid held high and res_ready = 1 → grant order 0,1,2,3,0; each requester keeps its own angle and the res_id sequence matches.
- Watchdog: core_done never asserted → res_valid exactly TIMEOUT cycles after WAIT entry (40), res_err = 1, outputs 0; done and timeout together on cycle 39 → res_err = 0.
- Backpressure: res_ready = 0 for 10 cycles in RESP → outputs stable, req_ready stays 0, busy = 1; grant follows the cycle after res_ready rises.
- Reset mid-WAIT: drive reset = 0 for 1 cycle at WAIT cycle 5 → next cycle all outputs 0 and state IDLE; a later core_done is ignored; requester 0 is granted first after release.
